// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The address-error rule lives here so the RTL has a single definition of it.
package dmem_pkg;
  localparam int WORD_W        = 32;
  localparam int DEPTH_DEFAULT = 256;
  localparam int WAIT_DEFAULT  = 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Misaligned, or word index at or beyond depth. Full-width compare, so no wrap-around.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a core (master) and the data memory (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word array with byte-lane write enables, synchronous clear and a combinational read.
// Clear has priority over a write on the same edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] wmask;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wmask[8*gi +: 8] = {8{be[gi]}};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem_q[idx];
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept in IDLE, wait WAIT_CYCLES in BUSY,
// hold the response in RESP until the core takes it. rst is active-low, synchronous.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_DEFAULT
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              eff_we, eff_err, enter_resp, arr_we;
  logic [31:0]       eff_addr;
  logic [WORD_W-1:0] eff_wdata, arr_rdata;
  logic [3:0]        eff_be;

  // With zero wait states RESP is entered on the accepting edge, so the live bus
  // request must feed the array that cycle; otherwise the captured copy is used.
  always_comb begin
    if (state_q == IDLE) begin
      eff_we    = bus.req_we;
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
      eff_be    = bus.req_be;
    end else begin
      eff_we    = we_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      eff_be    = be_q;
    end
  end

  assign eff_err = addr_err(eff_addr, DEPTH_W);
  assign arr_we  = enter_resp && eff_we && !eff_err;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = WAIT_W;
          state_d = (WAIT_CYCLES > 0) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      err_d   = eff_err;
      rdata_d = (!eff_we && !eff_err) ? arr_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .clr   (!rst),
    .we    (arr_we),
    .idx   (eff_addr[IDX_W+1:2]),
    .wdata (eff_wdata),
    .be    (eff_be),
    .rdata (arr_rdata)
  );

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states (index 0) and one with none (index 1).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus2 ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_w2 (.clk(clk), .rst(rst), .bus(bus2));
  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .rst(rst), .bus(bus0));

  logic        d_valid [2];
  logic        d_we [2];
  logic        d_rsp_ready [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_be [2];
  logic        o_ready [2];
  logic        o_rvalid [2];
  logic        o_err [2];
  logic [31:0] o_rdata [2];

  assign bus2.req_valid = d_valid[0];
  assign bus2.req_we    = d_we[0];
  assign bus2.req_addr  = d_addr[0];
  assign bus2.req_wdata = d_wdata[0];
  assign bus2.req_be    = d_be[0];
  assign bus2.rsp_ready = d_rsp_ready[0];
  assign bus0.req_valid = d_valid[1];
  assign bus0.req_we    = d_we[1];
  assign bus0.req_addr  = d_addr[1];
  assign bus0.req_wdata = d_wdata[1];
  assign bus0.req_be    = d_be[1];
  assign bus0.rsp_ready = d_rsp_ready[1];
  assign o_ready[0]  = bus2.req_ready;
  assign o_rvalid[0] = bus2.rsp_valid;
  assign o_rdata[0]  = bus2.rsp_rdata;
  assign o_err[0]    = bus2.rsp_err;
  assign o_ready[1]  = bus0.req_ready;
  assign o_rvalid[1] = bus0.rsp_valid;
  assign o_rdata[1]  = bus0.rsp_rdata;
  assign o_err[1]    = bus0.rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mdl [2][256];
  int          lat_exp [2];
  int          checks   = 0;
  int          failures = 0;

  // Reference memory: computes the expected response and applies writes.
  task automatic model_txn(input int s, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
    e = '0;
    if (addr[1:0] != 2'b00 || addr[31:2] >= 30'd256) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[s][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.rdata = mdl[s][addr[9:2]];
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mdl[s][i] = '0;
  endtask

  // Drives one request, scrambles request fields while busy, returns the response and
  // the number of sampling points from acceptance to rsp_valid (99 = timeout).
  task automatic run_txn(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    lat   = 99;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    d_valid[s] = 1'b1; d_we[s] = we; d_addr[s] = addr; d_wdata[s] = wdata; d_be[s] = be;
    d_rsp_ready[s] = 1'b1;
    guard = 0;
    while (!o_ready[s] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready[s]) begin
      d_valid[s] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      d_we[s] = 1'($urandom); d_addr[s] = $urandom; d_wdata[s] = $urandom; d_be[s] = 4'($urandom);
      if (o_rvalid[s]) begin
        lat   = i;
        rdata = o_rdata[s];
        err   = o_err[s];
        break;
      end
    end
    d_valid[s] = 1'b0;
    @(posedge clk);
    $display("txn dut=%0d we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
             s, we, addr, wdata, be, rdata, err, lat);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      checks++; if (o_ready[s] !== 1'b1) begin failures++; $display("FAIL reset_req_ready dut=%0d got=%b exp=1", s, o_ready[s]); end
      checks++; if (o_rvalid[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid dut=%0d got=%b exp=0", s, o_rvalid[s]); end
      checks++; if (o_rdata[s] !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata dut=%0d got=%h exp=0", s, o_rdata[s]); end
      checks++; if (o_err[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_err dut=%0d got=%b exp=0", s, o_err[s]); end
    end
  endtask

  task automatic test_write_read();
    logic        t_we [2]   = '{1'b1, 1'b0};
    logic [31:0] t_wd [2]   = '{32'hDEADBEEF, 32'h0};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 2; i++) begin
      model_txn(0, t_we[i], 32'h10, t_wd[i], 4'hF, e); exp_q.push_back(e);
      run_txn(0, t_we[i], 32'h10, t_wd[i], 4'hF, rd, er, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL wr_rdata step=%0d got=%h exp=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL wr_err step=%0d got=%b exp=%b", i, er, e.err); end
      checks++; if (lat != lat_exp[0]) begin failures++; $display("FAIL wr_latency step=%0d got=%0d exp=%0d", i, lat, lat_exp[0]); end
    end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_readback got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_enable();
    logic        t_we [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_wd [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [3:0]  t_be [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'hF};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      model_txn(0, t_we[i], 32'h20, t_wd[i], t_be[i], e); exp_q.push_back(e);
      run_txn(0, t_we[i], 32'h20, t_wd[i], t_be[i], rd, er, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL be_rdata step=%0d got=%h exp=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL be_err step=%0d got=%b exp=%b", i, er, e.err); end
      checks++; if (lat != lat_exp[0]) begin failures++; $display("FAIL be_latency step=%0d got=%0d exp=%0d", i, lat, lat_exp[0]); end
    end
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic        t_we [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_ad [7] = '{32'h0, 32'h13, 32'h400, 32'h0, 32'h80000010, 32'h3FE, 32'h3FC};
    logic [31:0] t_wd [7] = '{32'hCAFEF00D, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h5A5A5A5A, 32'h0};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 7; i++) begin
      model_txn(0, t_we[i], t_ad[i], t_wd[i], 4'hF, e); exp_q.push_back(e);
      run_txn(0, t_we[i], t_ad[i], t_wd[i], 4'hF, rd, er, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL err_rdata addr=%h got=%h exp=%h", t_ad[i], rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL err_flag addr=%h got=%b exp=%b", t_ad[i], er, e.err); end
      checks++; if (lat != lat_exp[0]) begin failures++; $display("FAIL err_latency addr=%h got=%0d exp=%0d", t_ad[i], lat, lat_exp[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ad, wd; logic er, we; logic [3:0] be; int lat, s; exp_t e;
    for (int i = 0; i < 24; i++) begin
      s  = i % 2;
      we = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) ad = ad + 32'd2;
      if ($urandom_range(0, 9) == 0) ad = ad | 32'h0001_0000;
      wd = $urandom;
      be = 4'($urandom);
      model_txn(s, we, ad, wd, be, e); exp_q.push_back(e);
      run_txn(s, we, ad, wd, be, rd, er, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL b2b_rdata i=%0d got=%h exp=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL b2b_err i=%0d got=%b exp=%b", i, er, e.err); end
      checks++; if (lat != lat_exp[s]) begin failures++; $display("FAIL b2b_latency i=%0d got=%0d exp=%0d", i, lat, lat_exp[s]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat, guard; exp_t e;
    model_txn(1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, e); exp_q.push_back(e);
    run_txn(1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, rd, er, lat);
    e = exp_q.pop_front();
    checks++; if (lat != lat_exp[1]) begin failures++; $display("FAIL bp_write_latency got=%0d exp=%0d", lat, lat_exp[1]); end
    model_txn(1, 1'b0, 32'h40, 32'h0, 4'hF, e); exp_q.push_back(e);
    @(negedge clk);
    d_valid[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h40; d_be[1] = 4'hF; d_rsp_ready[1] = 1'b0;
    guard = 0;
    while (!o_ready[1] && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d_valid[1] = 1'b0; d_addr[1] = $urandom; d_we[1] = 1'($urandom);
      checks++; if (o_rvalid[1] !== 1'b1) begin failures++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, o_rvalid[1]); end
      checks++; if (o_rdata[1] !== e.rdata) begin failures++; $display("FAIL bp_rdata k=%0d got=%h exp=%h", k, o_rdata[1], e.rdata); end
      checks++; if (o_err[1] !== e.err) begin failures++; $display("FAIL bp_err k=%0d got=%b exp=%b", k, o_err[1], e.err); end
      checks++; if (o_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_req_ready k=%0d got=%b exp=0", k, o_ready[1]); end
    end
    $display("txn dut=1 we=0 addr=00000040 held 5 cycles rdata=%h err=%0b", o_rdata[1], o_err[1]);
    d_rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_rvalid[1] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", o_rvalid[1]); end
    checks++; if (o_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", o_ready[1]); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic er; int lat, guard; logic seen; exp_t e;
    @(negedge clk);
    d_valid[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h8; d_wdata[0] = 32'h55; d_be[0] = 4'hF;
    d_rsp_ready[0] = 1'b1;
    guard = 0;
    while (!o_ready[0] && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    checks++; if (o_ready[0] !== 1'b0) begin failures++; $display("FAIL rst_busy_ready got=%b exp=0", o_ready[0]); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    $display("txn dut=0 we=1 addr=00000008 wdata=00000055 aborted by reset");
    checks++; if (o_ready[0] !== 1'b1) begin failures++; $display("FAIL rst_abort_ready got=%b exp=1", o_ready[0]); end
    checks++; if (o_rvalid[0] !== 1'b0) begin failures++; $display("FAIL rst_abort_valid got=%b exp=0", o_rvalid[0]); end
    checks++; if (o_rdata[0] !== 32'h0) begin failures++; $display("FAIL rst_abort_rdata got=%h exp=0", o_rdata[0]); end
    checks++; if (o_err[0] !== 1'b0) begin failures++; $display("FAIL rst_abort_err got=%b exp=0", o_err[0]); end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_rvalid[0]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_response got=%b exp=0", seen); end
    model_txn(0, 1'b0, 32'h8, 32'h0, 4'hF, e); exp_q.push_back(e);
    run_txn(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rst_readback got=%h exp=%h", rd, e.rdata); end
    checks++; if (er !== e.err) begin failures++; $display("FAIL rst_readback_err got=%b exp=%b", er, e.err); end
    checks++; if (lat != lat_exp[0]) begin failures++; $display("FAIL rst_readback_latency got=%0d exp=%0d", lat, lat_exp[0]); end
  endtask

  initial begin
    lat_exp[0] = 3;
    lat_exp[1] = 1;
    for (int s = 0; s < 2; s++) begin
      d_valid[s] = 1'b0; d_we[s] = 1'b0; d_addr[s] = '0; d_wdata[s] = '0; d_be[s] = '0;
      d_rsp_ready[s] = 1'b0;
    end
    model_clear();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
